// File: rtl/reset_sequencer.sv
// Staged reset sequencer: holds all domains in reset, then releases mem, periph, cpu in order.
// Optional watchdog enabled by defining RESET_SEQUENCER_WDT_EN.
module reset_sequencer #(
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_DELAY = 4,
  parameter int WDT_TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       dtr_rst,
  input  logic       btn_rst,
  input  logic       wdt_kick,
  output logic       rst_mem,
  output logic       rst_periph,
  output logic       rst_cpu,
  output logic       busy,
  output logic [1:0] rst_cause
);

  typedef enum logic [1:0] {
    S_HOLD       = 2'd0,
    S_REL_MEM    = 2'd1,
    S_REL_PERIPH = 2'd2,
    S_RUN        = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] STAGE_LAST = 8'(STAGE_DELAY - 1);

  localparam logic [1:0] CAUSE_POR = 2'd0;
  localparam logic [1:0] CAUSE_DTR = 2'd1;
  localparam logic [1:0] CAUSE_BTN = 2'd2;
  localparam logic [1:0] CAUSE_WDT = 2'd3;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] cause_q, cause_d;
  logic       rst_mem_q, rst_mem_d;
  logic       rst_periph_q, rst_periph_d;
  logic       rst_cpu_q, rst_cpu_d;
  logic       busy_q, busy_d;
  logic       wdt_exp;
  logic       req;

`ifdef RESET_SEQUENCER_WDT_EN
  localparam logic [15:0] WDT_LAST = 16'(WDT_TIMEOUT - 1);

  logic [15:0] wdt_q, wdt_d;

  // A kick landing in the expiry cycle wins over the expiry.
  assign wdt_exp = (state_q == S_RUN) && (wdt_q == WDT_LAST) && !wdt_kick;

  always_comb begin
    wdt_d = '0;
    if (state_q == S_RUN && !wdt_kick && !wdt_exp) begin
      wdt_d = wdt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_d;
    end
  end
`else
  logic unused_wdt;
  assign unused_wdt = wdt_kick ^ (WDT_TIMEOUT == 0);
  assign wdt_exp    = 1'b0;
`endif

  assign req = btn_rst | dtr_rst | wdt_exp;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= S_HOLD;
      cnt_q        <= '0;
      cause_q      <= CAUSE_POR;
      rst_mem_q    <= 1'b1;
      rst_periph_q <= 1'b1;
      rst_cpu_q    <= 1'b1;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cause_q      <= cause_d;
      rst_mem_q    <= rst_mem_d;
      rst_periph_q <= rst_periph_d;
      rst_cpu_q    <= rst_cpu_d;
      busy_q       <= busy_d;
    end
  end

  // Any request restarts HOLD from zero, so a held request keeps the count pinned.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    if (req) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      if (btn_rst) begin
        cause_d = CAUSE_BTN;
      end else if (dtr_rst) begin
        cause_d = CAUSE_DTR;
      end else begin
        cause_d = CAUSE_WDT;
      end
    end else begin
      unique case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = S_REL_MEM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_REL_MEM: begin
          if (cnt_q == STAGE_LAST) begin
            state_d = S_REL_PERIPH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_REL_PERIPH: begin
          if (cnt_q == STAGE_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_RUN: begin
          cnt_d = '0;
        end
        default: begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs decode the next state so they are registered alongside it.
  always_comb begin
    rst_mem_d    = (state_d == S_HOLD);
    rst_periph_d = (state_d == S_HOLD) || (state_d == S_REL_MEM);
    rst_cpu_d    = (state_d != S_RUN);
    busy_d       = rst_mem_d | rst_periph_d | rst_cpu_d;
  end

  assign rst_mem    = rst_mem_q;
  assign rst_periph = rst_periph_q;
  assign rst_cpu    = rst_cpu_q;
  assign busy       = busy_q;
  assign rst_cause  = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: reference model tracks cycles since the last reset event.
module tb_reset_sequencer;

  localparam int H = 16;
  localparam int S = 4;
  localparam int T = 100;
`ifdef RESET_SEQUENCER_WDT_EN
  localparam bit WDT_EN = 1'b1;
`else
  localparam bit WDT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       nreset = 1'b1;
  logic       dtr_rst = 1'b0;
  logic       btn_rst = 1'b0;
  logic       wdt_kick = 1'b0;
  logic       rst_mem, rst_periph, rst_cpu, busy;
  logic [1:0] rst_cause;

  int checks = 0;
  int errors = 0;

  reset_sequencer #(.HOLD_CYCLES(H), .STAGE_DELAY(S), .WDT_TIMEOUT(T)) dut (
    .clk(clk), .nreset(nreset), .dtr_rst(dtr_rst), .btn_rst(btn_rst),
    .wdt_kick(wdt_kick), .rst_mem(rst_mem), .rst_periph(rst_periph),
    .rst_cpu(rst_cpu), .busy(busy), .rst_cause(rst_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: domains release at fixed offsets from the last reset event.
  int m_since = 0;
  int m_cause = 0;
  int m_w     = 0;

  always @(negedge nreset) begin
    m_since = 0;
    m_cause = 0;
    m_w     = 0;
  end

  always @(posedge clk) begin
    bit run, wexp;
    if (nreset) begin
      run  = (m_since >= H + 2 * S);
      wexp = WDT_EN && run && (m_w == T - 1) && !wdt_kick;
      if (btn_rst || dtr_rst || wexp) begin
        m_since = 0;
        m_cause = btn_rst ? 2 : (dtr_rst ? 1 : 3);
      end else if (m_since < 1000) begin
        m_since++;
      end
      m_w = (run && !wdt_kick) ? m_w + 1 : 0;
    end
    #1;
    chk("rst_mem",    int'(rst_mem),    int'(m_since < H));
    chk("rst_periph", int'(rst_periph), int'(m_since < H + S));
    chk("rst_cpu",    int'(rst_cpu),    int'(m_since < H + 2 * S));
    chk("busy",       int'(busy),       int'(m_since < H + 2 * S));
    chk("rst_cause",  int'(rst_cause),  m_cause);
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int saved_cause;
    #1 nreset = 1'b0;
    repeat (5) @(negedge clk);
    nreset = 1'b1;

    // Power-on release timeline with defaults.
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #2;
      if (k == 15) chk("por_mem_held_15", int'(rst_mem), 1);
      if (k == 16) begin
        chk("por_mem_rel_16", int'(rst_mem), 0);
        chk("por_periph_held_16", int'(rst_periph), 1);
      end
      if (k == 20) begin
        chk("por_periph_rel_20", int'(rst_periph), 0);
        chk("por_cpu_held_20", int'(rst_cpu), 1);
      end
      if (k == 24) begin
        chk("por_cpu_rel_24", int'(rst_cpu), 0);
        chk("por_busy_24", int'(busy), 0);
        chk("por_cause", int'(rst_cause), 0);
      end
    end

    // DTR held 16 cycles from RUN.
    @(negedge clk); dtr_rst = 1'b1;
    @(posedge clk); #2;
    chk("dtr_mem_asserted", int'(rst_mem), 1);
    chk("dtr_cpu_asserted", int'(rst_cpu), 1);
    chk("dtr_cause", int'(rst_cause), 1);
    repeat (16) @(negedge clk);
    dtr_rst = 1'b0;
    repeat (23) @(posedge clk);
    #2 chk("dtr_cpu_held_23", int'(rst_cpu), 1);
    @(posedge clk); #2;
    chk("dtr_cpu_rel_24", int'(rst_cpu), 0);

    // Button and DTR together while in REL_PERIPH.
    @(negedge clk); dtr_rst = 1'b1;
    @(negedge clk); dtr_rst = 1'b0;
    repeat (20) @(posedge clk);
    #2 chk("relp_periph_low", int'(rst_periph), 0);
    chk("relp_cpu_high", int'(rst_cpu), 1);
    @(negedge clk); btn_rst = 1'b1; dtr_rst = 1'b1;
    @(posedge clk); #2;
    chk("both_mem_reasserted", int'(rst_mem), 1);
    chk("both_cause_btn", int'(rst_cause), 2);
    @(negedge clk); btn_rst = 1'b0; dtr_rst = 1'b0;

    // nreset during a DTR-initiated HOLD acts before the next edge.
    repeat (30) @(negedge clk);
    dtr_rst = 1'b1;
    @(negedge clk); dtr_rst = 1'b0;
    @(posedge clk); #3;
    chk("hold_cause_dtr", int'(rst_cause), 1);
    nreset = 1'b0;
    #1;
    chk("async_mem", int'(rst_mem), 1);
    chk("async_periph", int'(rst_periph), 1);
    chk("async_cpu", int'(rst_cpu), 1);
    chk("async_busy", int'(busy), 1);
    chk("async_cause", int'(rst_cause), 0);
    repeat (2) @(negedge clk);
    nreset = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      dtr_rst  = ($urandom % 60) == 0;
      btn_rst  = ($urandom % 90) == 0;
      wdt_kick = ($urandom % 40) == 0;
      if (($urandom % 700) == 0) nreset = 1'b0;
      else nreset = 1'b1;
    end
    @(negedge clk);
    nreset = 1'b1; dtr_rst = 1'b0; btn_rst = 1'b0; wdt_kick = 1'b1;

    // Settle into RUN, then a long quiet stretch.
    repeat (40) @(negedge clk);
    wdt_kick = 1'b0;
    saved_cause = int'(rst_cause);
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      wdt_kick = WDT_EN && ((i % 50) == 0);
    end
    @(negedge clk); wdt_kick = 1'b0;
    chk("quiet_cpu_low", int'(rst_cpu), 0);
    chk("quiet_cause_kept", int'(rst_cause), saved_cause);

    // Stop kicking; the model decides whether the watchdog fires.
    repeat (150) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
